translayer_drain: RTL and testbench
===================================

# translayer_drain

Consumer for the transaction layer's two destination FIFOs (D0, D1). It drains both with round-robin arbitration using their pop/empty/valid handshake and merges the words into one registered output stream with a downstream ready handshake. It counts words per destination and flags words whose destination bit does not match the FIFO they came from. It sits directly after the D0/D1 FIFOs, at the egress end of the transaction layer.

## Interface

Parameters:
- DW, 6, word width; matches FIFO data width.
- CW, 8, width of per-destination word counters.
- RB, 4, index of the destination-select bit inside a word (0 = D0, 1 = D1).

Ports:
- clk  input  1  clock; single clock domain; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = drain FIFOs; 0 = finish the word in flight, then stop.
- empty_d0  input  1  D0 FIFO empty flag.
- empty_d1  input  1  D1 FIFO empty flag.
- data_d0  input  DW  D0 FIFO read data; valid one cycle after pop_d0.
- valid_d0  input  1  D0 FIFO read-data valid.
- data_d1  input  DW  D1 FIFO read data.
- valid_d1  input  1  D1 FIFO read-data valid.
- pop_d0  output  1  single-cycle pop strobe to D0 FIFO.
- pop_d1  output  1  single-cycle pop strobe to D1 FIFO.
- ready_in  input  1  downstream can accept a word this cycle.
- data_out  output  DW  merged output word (registered).
- valid_out  output  1  data_out holds a word.
- src_out  output  1  source FIFO of data_out (0 = D0, 1 = D1).
- count_d0  output  CW  words captured from D0.
- count_d1  output  CW  words captured from D1.
- route_error  output  1  sticky; a word's bit RB did not match its source.
- underflow_error  output  1  sticky; pop issued but no valid returned.
- idle_out  output  1  1 while FSM is in IDLE.

## Operation

- FSM states: IDLE, ARB, WAIT, HOLD.
- IDLE:
  - idle_out = 1; no pops.
  - enable = 1 -> ARB next cycle.
- ARB:
  - enable = 0 -> IDLE.
  - Else, if any FIFO is non-empty: pick a source, assert that pop for exactly this cycle, store the source in cur_src, go to WAIT.
  - Both FIFOs empty -> stay in ARB.
- Arbitration:
  - Both non-empty: serve !last_src.
  - One non-empty: serve that one.
  - last_src is updated to cur_src on every capture.
  - last_src resets to 1, so D0 is served first.
- WAIT (cycle after pop):
  - Valid of cur_src = 1: load data_out from that FIFO's data, set src_out = cur_src, increment that counter, go to HOLD.
  - If bit RB of the captured word != cur_src: set route_error. The word is still forwarded.
  - Valid = 0: set underflow_error, capture nothing, go to ARB.
- HOLD:
  - valid_out = 1; data_out and src_out stay stable.
  - ready_in = 1 at a rising edge completes the transfer; go to ARB.
  - Otherwise stay in HOLD indefinitely. No pops are issued while in HOLD.
- enable deasserted in WAIT or HOLD: the in-flight word completes normally, then ARB -> IDLE.
- Counters wrap modulo 2^CW (0xFF + 1 -> 0x00).
- Error flags are cleared only by reset.
- Never assert pop_d0 and pop_d1 together.
- Never pop a FIFO whose empty flag is 1 in that cycle.

## Timing

- Reset values:
  - state = IDLE, idle_out = 1.
  - pop_d0 = pop_d1 = 0, valid_out = 0, data_out = 0, src_out = 0.
  - count_d0 = count_d1 = 0, both error flags = 0, last_src = 1.
- pop_dX is a combinational decode of state ARB plus the arbitration choice. It is high for one cycle per word.
- Latency, with ready_in held at 1:
  - pop at cycle T, capture at edge ending T+1, valid_out high in T+2, transfer at the edge ending T+2.
  - The next pop can occur at T+3, giving a maximum throughput of 1 word per 3 cycles.
- Backpressure: each cycle ready_in is 0 in HOLD extends HOLD by one cycle, with no data loss.
- Reset mid-operation: next cycle all reset values apply. A popped-but-uncaptured word is discarded and no error is flagged.
- IDLE -> ARB takes 1 cycle after enable rises. The first pop can be in the cycle following that edge.

## Test plan

- Reset then enable = 1, D0 holds 0x05, D1 empty, ready_in = 1 -> pop_d0 for 1 cycle; valid_out = 1 two cycles later with data_out = 0x05, src_out = 0; count_d0 = 1.
- Both FIFOs hold 3 words (D0: 0x01, 0x02, 0x03; D1: 0x11, 0x12, 0x13) -> output order 0x01, 0x11, 0x02, 0x12, 0x03, 0x13; pops alternate; count_d0 = count_d1 = 3; no errors.
- Word 0x15 in D0 (bit 4 = 1) -> forwarded unchanged, route_error = 1 and stays 1 until reset.
- ready_in = 0 for 5 cycles while valid_out = 1 -> data_out stable, no pops; one transfer when ready_in rises.
- pop issued but valid_d0 forced to 0 in WAIT -> underflow_error = 1, count_d0 unchanged, valid_out stays 0, FSM returns to ARB.
- 256 D1 words -> count_d1 wraps to 0x00. In a separate run, reset asserted during WAIT -> all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/translayer_drain.sv
// Drains the transaction layer's D0/D1 destination FIFOs with round-robin
// arbitration and merges the words into one registered, ready-gated stream.
module translayer_drain #(
    parameter int DW = 6,
    parameter int CW = 8,
    parameter int RB = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          empty_d0,
    input  logic          empty_d1,
    input  logic [DW-1:0] data_d0,
    input  logic          valid_d0,
    input  logic [DW-1:0] data_d1,
    input  logic          valid_d1,
    output logic          pop_d0,
    output logic          pop_d1,
    input  logic          ready_in,
    output logic [DW-1:0] data_out,
    output logic          valid_out,
    output logic          src_out,
    output logic [CW-1:0] count_d0,
    output logic [CW-1:0] count_d1,
    output logic          route_error,
    output logic          underflow_error,
    output logic          idle_out,
    output logic [1:0]    fsm_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ARB  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          cur_src;
    logic          last_src;
    logic          pick_src;
    logic          pick_any;
    logic          do_pop;
    logic          sel_valid;
    logic [DW-1:0] sel_data;

    // Handshakes: a FIFO word is requested by a one-cycle pop and must show
    // valid on the following cycle; an output word is held in HOLD with
    // valid_out=1 and is consumed on any rising edge where ready_in=1.
    always_comb begin
        pick_any = !empty_d0 || !empty_d1;
        if (!empty_d0 && !empty_d1) begin
            pick_src = ~last_src;
        end else begin
            pick_src = empty_d0;
        end
        do_pop    = (state == ARB) && enable && pick_any;
        pop_d0    = do_pop && !pick_src;
        pop_d1    = do_pop && pick_src;
        sel_valid = cur_src ? valid_d1 : valid_d0;
        sel_data  = cur_src ? data_d1 : data_d0;
        valid_out = (state == HOLD);
        idle_out  = (state == IDLE);
        fsm_state = state;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (enable) state_nxt = ARB;
            ARB: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (pick_any) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: state_nxt = sel_valid ? HOLD : ARB;
            HOLD: if (ready_in) state_nxt = ARB;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            cur_src         <= 1'b0;
            last_src        <= 1'b1;
            data_out        <= '0;
            src_out         <= 1'b0;
            count_d0        <= '0;
            count_d1        <= '0;
            route_error     <= 1'b0;
            underflow_error <= 1'b0;
        end else begin
            state <= state_nxt;
            if (do_pop) begin
                cur_src <= pick_src;
            end
            if (state == WAIT) begin
                if (sel_valid) begin
                    data_out <= sel_data;
                    src_out  <= cur_src;
                    last_src <= cur_src;
                    if (cur_src) begin
                        count_d1 <= count_d1 + CW'(1);
                    end else begin
                        count_d0 <= count_d0 + CW'(1);
                    end
                    // Misrouted words are still forwarded; only the flag records it.
                    if (sel_data[RB] != cur_src) begin
                        route_error <= 1'b1;
                    end
                end else begin
                    underflow_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_translayer_drain.sv
// Directed bench for translayer_drain: behavioural D0/D1 FIFO models feed the
// DUT and every accepted output word is logged for comparison.
module tb_translayer_drain;
  localparam int DW = 6;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          empty_d0 = 1'b1;
  logic          empty_d1 = 1'b1;
  logic [DW-1:0] data_d0 = '0;
  logic          valid_d0 = 1'b0;
  logic [DW-1:0] data_d1 = '0;
  logic          valid_d1 = 1'b0;
  logic          pop_d0;
  logic          pop_d1;
  logic          ready_in = 1'b1;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          src_out;
  logic [CW-1:0] count_d0;
  logic [CW-1:0] count_d1;
  logic          route_error;
  logic          underflow_error;
  logic          idle_out;
  logic [1:0]    fsm_state;

  translayer_drain #(.DW(DW), .CW(CW), .RB(4)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .empty_d0(empty_d0), .empty_d1(empty_d1),
    .data_d0(data_d0), .valid_d0(valid_d0),
    .data_d1(data_d1), .valid_d1(valid_d1),
    .pop_d0(pop_d0), .pop_d1(pop_d1), .ready_in(ready_in),
    .data_out(data_out), .valid_out(valid_out), .src_out(src_out),
    .count_d0(count_d0), .count_d1(count_d1),
    .route_error(route_error), .underflow_error(underflow_error),
    .idle_out(idle_out), .fsm_state(fsm_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass = 0;

  // FIFO models and output log
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW:0]   out_q[$];
  logic [DW:0]   exp_q[$];
  logic          force_inv0 = 1'b0;
  int            pops0 = 0;
  int            pops1 = 0;
  int            prot_err = 0;
  int            cyc = 0;
  int            pop_cyc = 0;
  int            xfer_cyc = 0;
  logic          s_pop0, s_pop1, s_xfer, s_src;
  logic [DW-1:0] s_data;

  always @(negedge clk) begin
    s_pop0 = pop_d0;
    s_pop1 = pop_d1;
    s_xfer = valid_out && ready_in;
    s_src  = src_out;
    s_data = data_out;
  end

  always @(posedge clk) begin
    if ((s_pop0 && s_pop1) || (s_pop0 && empty_d0) || (s_pop1 && empty_d1)) prot_err++;
    valid_d0 <= 1'b0;
    valid_d1 <= 1'b0;
    if (s_pop0) begin
      pops0++;
      pop_cyc = cyc;
      if (q0.size() > 0) begin
        data_d0  <= q0.pop_front();
        valid_d0 <= !force_inv0;
      end
    end
    if (s_pop1) begin
      pops1++;
      pop_cyc = cyc;
      if (q1.size() > 0) begin
        data_d1  <= q1.pop_front();
        valid_d1 <= 1'b1;
      end
    end
    empty_d0 <= (q0.size() == 0);
    empty_d1 <= (q1.size() == 0);
    if (s_xfer && !reset) begin
      out_q.push_back({s_src, s_data});
      xfer_cyc = cyc;
    end
    s_pop0 = 1'b0;
    s_pop1 = 1'b0;
    s_xfer = 1'b0;
    cyc++;
  end

  // driver tasks
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; enable = 1'b0; ready_in = 1'b1; force_inv0 = 1'b0;
    q0.delete(); q1.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_q.delete(); exp_q.delete();
    pops0 = 0; pops1 = 0;
    reset = 1'b0;
  endtask

  task automatic wait_out(input int n, input int budget, input string name);
    for (int i = 0; i < budget && out_q.size() < n; i++) @(negedge clk);
    n_total++;
    if (out_q.size() < n) $display("FAIL %s timeout: got %0d words, need %0d", name, out_q.size(), n);
    else n_pass++;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_total++;
    if ({idle_out, pop_d0, pop_d1, valid_out, src_out, route_error, underflow_error} !== 7'b1000000)
      $display("FAIL reset_flags: got %b need 1000000",
               {idle_out, pop_d0, pop_d1, valid_out, src_out, route_error, underflow_error});
    else n_pass++;
    n_total++;
    if (data_out !== 6'h00 || count_d0 !== 8'h00 || count_d1 !== 8'h00 || fsm_state !== 2'd0)
      $display("FAIL reset_values: data=%h c0=%h c1=%h st=%0d", data_out, count_d0, count_d1, fsm_state);
    else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    q0.push_back(6'h05);
    enable = 1'b1;
    wait_out(1, 20, "single");
    n_total++;
    if (out_q.size() < 1 || out_q[0] !== {1'b0, 6'h05})
      $display("FAIL single_word: got %h need %h", out_q.size() ? out_q[0] : 7'h7f, {1'b0, 6'h05});
    else n_pass++;
    n_total++;
    if (xfer_cyc - pop_cyc !== 2) $display("FAIL single_latency: got %0d need 2", xfer_cyc - pop_cyc);
    else n_pass++;
    n_total++;
    if (count_d0 !== 8'd1 || pops0 !== 1 || pops1 !== 0)
      $display("FAIL single_counts: c0=%0d pops0=%0d pops1=%0d need 1 1 0", count_d0, pops0, pops1);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] v0[3] = '{6'h01, 6'h02, 6'h03};
    logic [DW-1:0] v1[3] = '{6'h11, 6'h12, 6'h13};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(v0[i]); q1.push_back(v1[i]);
      exp_q.push_back({1'b0, v0[i]}); exp_q.push_back({1'b1, v1[i]});
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    enable = 1'b1;
    wait_out(6, 60, "round_robin");
    for (int i = 0; i < 6; i++) begin
      n_total++;
      if (i >= out_q.size() || out_q[i] !== exp_q[i])
        $display("FAIL rr_word%0d: got %h need %h", i, i < out_q.size() ? out_q[i] : 7'h7f, exp_q[i]);
      else n_pass++;
    end
    n_total++;
    if (count_d0 !== 8'd3 || count_d1 !== 8'd3 || route_error !== 1'b0 || underflow_error !== 1'b0)
      $display("FAIL rr_counts: c0=%0d c1=%0d re=%b ue=%b need 3 3 0 0",
               count_d0, count_d1, route_error, underflow_error);
    else n_pass++;
  endtask

  task automatic test_route_error();
    do_reset();
    q0.push_back(6'h15);
    enable = 1'b1;
    wait_out(1, 20, "route");
    n_total++;
    if (out_q.size() < 1 || out_q[0] !== {1'b0, 6'h15} || route_error !== 1'b1)
      $display("FAIL route_flag: word=%h re=%b need %h 1", out_q.size() ? out_q[0] : 7'h7f,
               route_error, {1'b0, 6'h15});
    else n_pass++;
    q0.push_back(6'h02);
    wait_out(2, 20, "route_second");
    n_total++;
    if (route_error !== 1'b1 || count_d0 !== 8'd2)
      $display("FAIL route_sticky: re=%b c0=%0d need 1 2", route_error, count_d0);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int p0, p1, stable_bad;
    do_reset();
    ready_in = 1'b0;
    q0.push_back(6'h07);
    q1.push_back(6'h13);
    @(posedge clk); #1;
    @(posedge clk); #1;
    enable = 1'b1;
    for (int i = 0; i < 20 && !valid_out; i++) @(negedge clk);
    p0 = pops0; p1 = pops1; stable_bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (valid_out !== 1'b1 || data_out !== 6'h07 || src_out !== 1'b0 || pop_d0 || pop_d1) stable_bad++;
    end
    n_total++;
    if (stable_bad !== 0 || pops0 !== p0 || pops1 !== p1)
      $display("FAIL bp_hold: bad_cycles=%0d pops=%0d/%0d need 0 %0d/%0d", stable_bad, pops0, pops1, p0, p1);
    else n_pass++;
    @(posedge clk); #1;
    ready_in = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if (out_q.size() !== 1 || out_q[0] !== {1'b0, 6'h07})
      $display("FAIL bp_transfer: words=%0d first=%h need 1 %h", out_q.size(),
               out_q.size() ? out_q[0] : 7'h7f, {1'b0, 6'h07});
    else n_pass++;
    wait_out(2, 20, "bp_second");
    n_total++;
    if (out_q.size() < 2 || out_q[1] !== {1'b1, 6'h13})
      $display("FAIL bp_next: got %h need %h", out_q.size() > 1 ? out_q[1] : 7'h7f, {1'b1, 6'h13});
    else n_pass++;
  endtask

  task automatic test_underflow();
    do_reset();
    force_inv0 = 1'b1;
    q0.push_back(6'h09);
    enable = 1'b1;
    for (int i = 0; i < 20 && !underflow_error; i++) @(negedge clk);
    force_inv0 = 1'b0;
    n_total++;
    if (underflow_error !== 1'b1 || count_d0 !== 8'd0 || valid_out !== 1'b0 || fsm_state !== 2'd1)
      $display("FAIL underflow: ue=%b c0=%0d vo=%b st=%0d need 1 0 0 1",
               underflow_error, count_d0, valid_out, fsm_state);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_total++;
    if (out_q.size() !== 0 || underflow_error !== 1'b1)
      $display("FAIL underflow_quiet: words=%0d ue=%b need 0 1", out_q.size(), underflow_error);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int bad;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      q1.push_back(6'h10 | 6'(i & 15));
      exp_q.push_back({1'b1, 6'h10 | 6'(i & 15)});
    end
    enable = 1'b1;
    for (int i = 0; i < 1000 && out_q.size() < 255; i++) @(negedge clk);
    n_total++;
    if (count_d1 !== 8'hFF) $display("FAIL wrap_255: got %h need ff", count_d1);
    else n_pass++;
    wait_out(256, 40, "wrap");
    bad = 0;
    for (int i = 0; i < 256; i++) if (i >= out_q.size() || out_q[i] !== exp_q[i]) bad++;
    n_total++;
    if (bad !== 0 || count_d1 !== 8'h00 || count_d0 !== 8'h00 || route_error !== 1'b0)
      $display("FAIL wrap_0: bad_words=%0d c1=%h c0=%h re=%b need 0 00 00 0", bad, count_d1, count_d0, route_error);
    else n_pass++;
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    q0.push_back(6'h0A);
    enable = 1'b1;
    for (int i = 0; i < 20 && fsm_state !== 2'd2; i++) @(negedge clk);
    n_total++;
    if (fsm_state !== 2'd2) $display("FAIL rst_wait_reach: state=%0d need 2", fsm_state);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_total++;
    if ({idle_out, pop_d0, pop_d1, valid_out, src_out, route_error, underflow_error} !== 7'b1000000 ||
        data_out !== 6'h00 || count_d0 !== 8'h00 || count_d1 !== 8'h00 || fsm_state !== 2'd0)
      $display("FAIL rst_wait_values: flags=%b data=%h c0=%h c1=%h st=%0d",
               {idle_out, pop_d0, pop_d1, valid_out, src_out, route_error, underflow_error},
               data_out, count_d0, count_d1, fsm_state);
    else n_pass++;
    reset = 1'b0;
    repeat (6) @(negedge clk);
    n_total++;
    if (out_q.size() !== 0 || count_d0 !== 8'h00 || underflow_error !== 1'b0)
      $display("FAIL rst_wait_discard: words=%0d c0=%0d ue=%b need 0 0 0", out_q.size(), count_d0, underflow_error);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_route_error();
    test_backpressure();
    test_underflow();
    test_wrap();
    test_reset_in_wait();
    n_total++;
    if (prot_err !== 0) $display("FAIL pop_protocol: violations=%0d need 0", prot_err);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
